// File: rtl/wave_bank_sched_if.sv
// rtl/wave_bank_sched_if.sv - capture/display handshake bundle for the ping-pong bank scheduler
interface wave_bank_sched_if #(
    parameter int CNT_W = 8
);
    logic [9:0]       y_pos;
    logic             freeze;
    logic             cap_done;
    logic             cap_en;
    logic             wr_bank;
    logic             rd_bank;
    logic             rd_valid;
    logic [CNT_W-1:0] swap_cnt;
    logic             proto_err;

    // Drives timing/writer inputs and observes the scheduler decisions
    modport master (
        output y_pos, freeze, cap_done,
        input  cap_en, wr_bank, rd_bank, rd_valid, swap_cnt, proto_err
    );

    // The scheduler itself
    modport slave (
        input  y_pos, freeze, cap_done,
        output cap_en, wr_bank, rd_bank, rd_valid, swap_cnt, proto_err
    );
endinterface

// File: rtl/wave_bank_sched.sv
// rtl/wave_bank_sched.sv - ping-pong capture bank scheduler, swaps only at display frame start
module wave_bank_sched #(
    parameter int DIS_Y_END   = 255,
    parameter int HOLD_FRAMES = 6,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    wave_bank_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_READY   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    localparam logic [9:0] Y_END     = 10'(DIS_Y_END);
    localparam int         HOLD_LAST_I = (HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_LAST_I);

    state_t           r_state;
    logic             r_cap_en;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_bank_valid;
    logic [CNT_W-1:0] r_swap_cnt;
    logic             r_proto_err;
    logic [3:0]       r_hold_cnt;
    logic             r_frame_end_pre;

    logic             w_frame_end;
    logic             w_frame_new;

    // Blanking detect and first-visible-line pulse; needs a blanking line seen since reset
    always_comb begin
        w_frame_end = (bus.y_pos > Y_END);
        w_frame_new = !w_frame_end && r_frame_end_pre;
    end

    // Scheduler FSM: grant, wait for frame start, swap banks, then hold for display frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cap_en        <= 1'b0;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b1;
            r_bank_valid    <= 2'b00;
            r_swap_cnt      <= '0;
            r_proto_err     <= 1'b0;
            r_hold_cnt      <= 4'd0;
            r_frame_end_pre <= 1'b0;
        end else begin
            r_frame_end_pre <= w_frame_end;

            // A completion pulse is only meaningful while a grant is outstanding
            if (bus.cap_done && (r_state != S_CAPTURE)) begin
                r_proto_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!bus.freeze) begin
                        r_state  <= S_CAPTURE;
                        r_cap_en <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Completion wins over freeze: a finished frame is never thrown away
                    if (bus.cap_done) begin
                        r_state  <= S_READY;
                        r_cap_en <= 1'b0;
                    end else if (bus.freeze) begin
                        r_state  <= S_IDLE;
                        r_cap_en <= 1'b0;
                    end
                end
                S_READY: begin
                    // Freeze is ignored here so the completed frame always reaches the screen
                    if (w_frame_new) begin
                        r_rd_bank    <= r_wr_bank;
                        r_wr_bank    <= ~r_wr_bank;
                        r_bank_valid <= r_wr_bank ? 2'b10 : 2'b01;
                        r_swap_cnt   <= r_swap_cnt + 1'b1;
                        r_hold_cnt   <= 4'd0;
                        r_state      <= (HOLD_FRAMES == 0) ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_frame_new) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cap_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cap_en    = r_cap_en;
    assign bus.wr_bank   = r_wr_bank;
    assign bus.rd_bank   = r_rd_bank;
    assign bus.rd_valid  = r_bank_valid[r_rd_bank];
    assign bus.swap_cnt  = r_swap_cnt;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_wave_bank_sched.sv
// tb/tb_wave_bank_sched.sv - self-checking bench for wave_bank_sched
module tb_wave_bank_sched;

    localparam int HOLD = 6;

    logic clk;
    logic rst;

    wave_bank_sched_if #(.CNT_W(8)) bus ();

    wave_bank_sched #(
        .DIS_Y_END   (255),
        .HOLD_FRAMES (HOLD),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: abstract scheduler status, not a state encoding
    bit       m_granted;     // writer holds a grant
    bit       m_waiting;     // finished frame awaiting a display frame start
    int       m_holds_left;  // frame starts still to wait after a swap
    bit       m_wr;
    bit       m_rd;
    bit [1:0] m_valid;
    bit [7:0] m_swaps;
    bit       m_err;
    bit       m_prev_blank;

    task automatic model_update();
        bit blank;
        bit fnew;
        if (rst) begin
            m_granted = 0; m_waiting = 0; m_holds_left = 0;
            m_wr = 0; m_rd = 1; m_valid = 2'b00; m_swaps = 0;
            m_err = 0; m_prev_blank = 0;
        end else begin
            blank = (bus.y_pos > 10'd255);
            fnew  = !blank && m_prev_blank;
            m_prev_blank = blank;
            if (bus.cap_done && !m_granted) m_err = 1;
            if (m_granted) begin
                if (bus.cap_done) begin
                    m_granted = 0;
                    m_waiting = 1;
                end else if (bus.freeze) begin
                    m_granted = 0;
                end
            end else if (m_waiting) begin
                if (fnew) begin
                    m_rd = m_wr;
                    m_wr = !m_wr;
                    m_valid = 2'b00;
                    m_valid[m_rd] = 1'b1;
                    m_swaps = m_swaps + 8'd1;
                    m_waiting = 0;
                    m_holds_left = HOLD;
                end
            end else if (m_holds_left > 0) begin
                if (fnew) m_holds_left = m_holds_left - 1;
            end else if (!bus.freeze) begin
                m_granted = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("cap_en",    32'(bus.cap_en),    32'(m_granted));
        check("wr_bank",   32'(bus.wr_bank),   32'(m_wr));
        check("rd_bank",   32'(bus.rd_bank),   32'(m_rd));
        check("rd_valid",  32'(bus.rd_valid),  32'(m_valid[m_rd]));
        check("swap_cnt",  32'(bus.swap_cnt),  32'(m_swaps));
        check("proto_err", 32'(bus.proto_err), 32'(m_err));
        check("banks_differ", 32'(bus.rd_bank ^ bus.wr_bank), 32'd1);
    endtask

    // Advance one clock with the currently driven inputs and compare every output
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frame();
        bus.y_pos = 10'd300; step();
        bus.y_pos = 10'd0;   step();
    endtask

    initial begin
        rst = 1'b1;
        bus.y_pos = 10'd0; bus.freeze = 1'b0; bus.cap_done = 1'b0;

        // Reset values
        step();
        check("rst_cap_en", 32'(bus.cap_en), 32'd0);
        check("rst_rd_bank", 32'(bus.rd_bank), 32'd1);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);

        // First grant one cycle after reset release
        rst = 1'b0;
        step();
        check("grant_1", 32'(bus.cap_en), 32'd1);

        // Capture completes, swap at the first visible line after blanking
        bus.cap_done = 1'b1; step();
        bus.cap_done = 1'b0;
        check("done_drops_en", 32'(bus.cap_en), 32'd0);
        frame();
        check("swap1_rd", 32'(bus.rd_bank), 32'd0);
        check("swap1_wr", 32'(bus.wr_bank), 32'd1);
        check("swap1_valid", 32'(bus.rd_valid), 32'd1);
        check("swap1_cnt", 32'(bus.swap_cnt), 32'd1);

        // Hold for HOLD frame starts, then one more edge to grant
        for (int i = 0; i < HOLD; i++) begin
            frame();
            check("hold_no_grant", 32'(bus.cap_en), 32'd0);
        end
        step();
        check("grant_after_hold", 32'(bus.cap_en), 32'd1);

        // Freeze aborts the capture without touching the displayed bank
        bus.freeze = 1'b1; step();
        check("freeze_en", 32'(bus.cap_en), 32'd0);
        check("freeze_rd", 32'(bus.rd_bank), 32'd0);
        check("freeze_valid", 32'(bus.rd_valid), 32'd1);
        step();
        bus.freeze = 1'b0; step();
        check("regrant_en", 32'(bus.cap_en), 32'd1);
        check("regrant_wr", 32'(bus.wr_bank), 32'd1);

        // cap_done coincident with frame_new: swap deferred to the next frame start
        bus.y_pos = 10'd300; step();
        bus.y_pos = 10'd0; bus.cap_done = 1'b1; step();
        bus.cap_done = 1'b0;
        check("coinc_no_swap", 32'(bus.swap_cnt), 32'd1);
        frame();
        check("swap2_cnt", 32'(bus.swap_cnt), 32'd2);
        check("swap2_rd", 32'(bus.rd_bank), 32'd1);

        // Stray cap_done in HOLD flags an error only
        bus.cap_done = 1'b1; step();
        bus.cap_done = 1'b0;
        check("proto_err_set", 32'(bus.proto_err), 32'd1);
        check("proto_rd", 32'(bus.rd_bank), 32'd1);
        frame();

        // Reset mid-hold
        rst = 1'b1; step();
        check("midrst_err", 32'(bus.proto_err), 32'd0);
        check("midrst_cnt", 32'(bus.swap_cnt), 32'd0);
        check("midrst_rd", 32'(bus.rd_bank), 32'd1);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.freeze   = ($urandom_range(0, 9) == 0);
            bus.cap_done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0)
                bus.y_pos = 10'($urandom_range(256, 1023));
            else
                bus.y_pos = 10'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0; bus.cap_done = 1'b0; bus.freeze = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
